// File: rtl/parallel_transfer_pipe.sv
// rtl/parallel_transfer_pipe.sv - parametrised valid/ready register pipe with bubble collapse, flush, taps and occupancy
module parallel_transfer_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [WIDTH*STAGES-1:0]   taps,
  output logic [STAGES-1:0]         tap_valid,
  output logic [CNT_W-1:0]          count
);

  generate
    if ((2 ** CNT_W) <= STAGES) begin : g_bad_cnt_w
      $error("parallel_transfer_pipe: CNT_W too narrow for STAGES");
    end
  endgenerate

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [CNT_W-1:0]  count_q;

  logic [STAGES-1:0] move;
  logic [STAGES-1:0] free;
  logic              accept;
  logic              consume;

  // Resolve moves from the output backwards so a freed stage can be refilled in the same cycle.
  always_comb begin
    move = '0;
    free = '0;
    move[STAGES-1] = valid_q[STAGES-1] & out_ready;
    free[STAGES-1] = ~valid_q[STAGES-1] | move[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      move[i] = valid_q[i] & free[i+1];
      free[i] = ~valid_q[i] | move[i];
    end
  end

  assign in_ready = free[0] & ~flush;
  assign accept   = in_valid & in_ready;
  assign consume  = move[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      // Data is deliberately left in place; only the valid bits are dropped.
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        data_q[0]  <= in_data;
        valid_q[0] <= 1'b1;
      end else if (move[0]) begin
        valid_q[0] <= 1'b0;
      end

      for (int i = 1; i < STAGES; i++) begin
        if (move[i-1]) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= 1'b1;
        end else if (move[i]) begin
          valid_q[i] <= 1'b0;
        end
      end

      case ({accept, consume})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_taps
      assign taps[g*WIDTH +: WIDTH] = data_q[g];
    end
  endgenerate

  assign tap_valid = valid_q;
  assign out_data  = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign count     = count_q;

endmodule
